player_ctrl: RTL and testbench

- Parametrised successor of the single-keycode player mover: multi-slot keyboard decode, saturating movement with configurable step and bounds, and an edge-triggered, rate-limited fire request gated by bullet availability.
- Adds a lives/death state machine: hit → frozen death animation → respawn at centre, or game over.
- Sits between the USB keycode source and the bullet/sprite/collision logic; advances once per frame on frame_clk.

---
 rtl/space_inv_pkg.sv | 16 +
 rtl/player_ctrl_if.sv | 35 +++
 rtl/player_key_decode.sv | 27 ++
 rtl/player_ctrl.sv | 144 ++++++++++++++
 tb/tb_player_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/space_inv_pkg.sv
// space_inv_pkg: shared constants and types for the player controller.
//   KEY_A / KEY_D / KEY_SPACE : USB HID keycodes for left, right and fire
//   LIVES_W                   : width of the lives counter
//   player_state_t            : player life-cycle states
package space_inv_pkg;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam int         LIVES_W   = 3;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    DYING = 2'd1,
    OVER  = 2'd2
  } player_state_t;
endpackage

// File: rtl/player_ctrl_if.sv
// player_ctrl_if: bundles the player controller's keyboard/game-side signals.
//   keycodes       : NKEYS packed keycode slots, slot k = [8k+7:8k], 0 = empty
//   bullet_active  : player bullet on screen
//   hit            : player struck this frame
//   player_x       : current X position
//   shoot_bullet   : one-frame fire pulse
//   player_visible : sprite visibility (blinks while dying)
//   lives          : remaining lives
//   game_over      : sticky until Reset
// master = game/keyboard side, slave = player_ctrl.
interface player_ctrl_if
  import space_inv_pkg::*;
#(
  parameter int POS_W = 10,
  parameter int NKEYS = 4
) ();
  logic [8*NKEYS-1:0] keycodes;
  logic               bullet_active;
  logic               hit;
  logic [POS_W-1:0]   player_x;
  logic               shoot_bullet;
  logic               player_visible;
  logic [LIVES_W-1:0] lives;
  logic               game_over;

  modport master (
    output keycodes, bullet_active, hit,
    input  player_x, shoot_bullet, player_visible, lives, game_over
  );

  modport slave (
    input  keycodes, bullet_active, hit,
    output player_x, shoot_bullet, player_visible, lives, game_over
  );
endinterface

// File: rtl/player_key_decode.sv
// player_key_decode: scans NKEYS keycode slots for the movement and fire keys.
//   keycodes : packed slots, slot k = [8k+7:8k]
//   left     : some slot holds KEY_A
//   right    : some slot holds KEY_D
//   fire     : some slot holds KEY_SPACE
// Slot order and duplicates do not matter.
module player_key_decode
  import space_inv_pkg::*;
#(
  parameter int NKEYS = 4
) (
  input  logic [8*NKEYS-1:0] keycodes,
  output logic               left,
  output logic               right,
  output logic               fire
);
  always_comb begin
    left  = 1'b0;
    right = 1'b0;
    fire  = 1'b0;
    for (int k = 0; k < NKEYS; k++) begin
      if (keycodes[8*k +: 8] == KEY_A)     left  = 1'b1;
      if (keycodes[8*k +: 8] == KEY_D)     right = 1'b1;
      if (keycodes[8*k +: 8] == KEY_SPACE) fire  = 1'b1;
    end
  end
endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: per-frame player mover with saturating movement, rate-limited
// fire and a lives/death state machine.
//   frame_clk : frame-rate clock
//   Reset     : asynchronous, active-high
//   pif       : player_ctrl_if.slave (keycodes, bullet_active, hit in;
//               player_x, shoot_bullet, player_visible, lives, game_over out)
// Build option: define PLAYER_AUTOFIRE_EN to let a held fire key re-fire
// whenever the cooldown has expired, without needing a fresh key edge.
//
// state | meaning
// ALIVE | moves and fires; hit -> DYING
// DYING | frozen, blinking for DEATH_FRAMES frames, then respawn or OVER
// OVER  | game over, invisible; only Reset leaves
module player_ctrl
  import space_inv_pkg::*;
#(
  parameter int POS_W         = 10,
  parameter int X_MIN         = 20,
  parameter int X_MAX         = 600,
  parameter int X_CENTER      = 320,
  parameter int STEP          = 2,
  parameter int NKEYS         = 4,
  parameter int FIRE_COOLDOWN = 15,
  parameter int DEATH_FRAMES  = 60,
  parameter int LIVES         = 3
) (
  input logic          frame_clk,
  input logic          Reset,
  player_ctrl_if.slave pif
);
  localparam int XW   = POS_W + 1;
  localparam int CD_W = $clog2(FIRE_COOLDOWN + 2);
  // Visibility uses bit 2 of the death counter, so keep at least 3 bits.
  localparam int DC_W = ($clog2(DEATH_FRAMES) < 3) ? 3 : $clog2(DEATH_FRAMES);
  localparam logic [DC_W-1:0] DC_END = DC_W'(DEATH_FRAMES - 1);

  player_state_t      state_q, state_nx;
  logic [POS_W-1:0]   x_q, x_nx, x_mv;
  logic               shoot_q, shoot_nx;
  logic [CD_W-1:0]    cd_q, cd_nx;
  logic               fire_prev_q;
  logic [LIVES_W-1:0] lives_q, lives_nx;
  logic [DC_W-1:0]    dcnt_q, dcnt_nx;
  logic               visible, over;
  logic               left, right, fire, fire_trig, fire_ok;
  logic [XW-1:0]      x_up, x_dn;

  player_key_decode #(.NKEYS(NKEYS)) u_dec (
    .keycodes (pif.keycodes),
    .left     (left),
    .right    (right),
    .fire     (fire)
  );

  // Extra top bit catches both overflow past X_MAX and borrow below zero.
  always_comb begin
    x_up = {1'b0, x_q} + XW'(STEP);
    x_dn = {1'b0, x_q} - XW'(STEP);
    x_mv = x_q;
    if (right && !left)
      x_mv = (x_up > XW'(X_MAX)) ? POS_W'(X_MAX) : x_up[POS_W-1:0];
    else if (left && !right)
      x_mv = (x_dn[POS_W] || (x_dn < XW'(X_MIN))) ? POS_W'(X_MIN) : x_dn[POS_W-1:0];
  end

`ifdef PLAYER_AUTOFIRE_EN
  assign fire_trig = fire;
`else
  assign fire_trig = fire & ~fire_prev_q;
`endif
  assign fire_ok = fire_trig && (cd_q == '0) && !pif.bullet_active;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ALIVE;
      x_q         <= POS_W'(X_CENTER);
      shoot_q     <= 1'b0;
      cd_q        <= '0;
      fire_prev_q <= 1'b0;
      lives_q     <= LIVES_W'(LIVES);
      dcnt_q      <= '0;
    end else begin
      state_q     <= state_nx;
      x_q         <= x_nx;
      shoot_q     <= shoot_nx;
      cd_q        <= cd_nx;
      fire_prev_q <= fire;
      lives_q     <= lives_nx;
      dcnt_q      <= dcnt_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    x_nx     = x_q;
    shoot_nx = 1'b0;
    cd_nx    = (cd_q != '0) ? cd_q - CD_W'(1) : '0;
    lives_nx = lives_q;
    dcnt_nx  = dcnt_q;
    visible  = 1'b1;
    over     = 1'b0;
    case (state_q)
      ALIVE: begin
        if (pif.hit) begin
          // Hit beats both movement and fire this frame.
          state_nx = DYING;
          lives_nx = lives_q - LIVES_W'(1);
          cd_nx    = '0;
          dcnt_nx  = '0;
        end else begin
          x_nx = x_mv;
          if (fire_ok) begin
            shoot_nx = 1'b1;
            cd_nx    = CD_W'(FIRE_COOLDOWN);
          end
        end
      end
      DYING: begin
        visible = ~dcnt_q[2];
        if (dcnt_q == DC_END) begin
          if (lives_q == '0) begin
            state_nx = OVER;
          end else begin
            state_nx = ALIVE;
            x_nx     = POS_W'(X_CENTER);
          end
        end else begin
          dcnt_nx = dcnt_q + DC_W'(1);
        end
      end
      OVER: begin
        visible = 1'b0;
        over    = 1'b1;
      end
      default: state_nx = ALIVE;
    endcase
  end

  assign pif.player_x       = x_q;
  assign pif.shoot_bullet   = shoot_q;
  assign pif.player_visible = visible;
  assign pif.lives          = lives_q;
  assign pif.game_over      = over;
endmodule

// File: tb/tb_player_ctrl.sv
module tb_player_ctrl;
  import space_inv_pkg::*;

`ifdef PLAYER_AUTOFIRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] keys = '0;
  logic        ba = 1'b0;
  logic        hit_in = 1'b0;

  int total = 0;
  int bad = 0;

  player_ctrl_if #(.POS_W(10), .NKEYS(4)) pif ();

  assign pif.keycodes      = keys;
  assign pif.bullet_active = ba;
  assign pif.hit           = hit_in;

  player_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .pif       (pif)
  );

  always #5 frame_clk = ~frame_clk;

  // Reference model: tracks frame numbers of the last shot and of the hit
  // instead of counters; cooldown of 15 means shots at least 16 frames apart.
  int m_n, m_x, m_lives, m_last_shot, m_hit_frame;
  bit m_over, m_pf, m_shot;

  function automatic bit has_key(logic [31:0] k, logic [7:0] code);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = k[8*i +: 8];
      if (b == code) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_n = 0; m_x = 320; m_lives = 3; m_last_shot = -1000;
    m_hit_frame = -1; m_over = 0; m_pf = 0; m_shot = 0;
  endfunction

  function automatic void model_step(logic [31:0] k, bit b, bit h);
    bit l, r, f;
    l = has_key(k, 8'h04);
    r = has_key(k, 8'h07);
    f = has_key(k, 8'h2C);
    m_n++;
    m_shot = 0;
    if (m_over) begin
    end else if (m_hit_frame >= 0) begin
      if (m_n - m_hit_frame == 60) begin
        if (m_lives == 0) m_over = 1;
        else begin m_hit_frame = -1; m_x = 320; end
      end
    end else if (h) begin
      m_lives--;
      m_hit_frame = m_n;
      m_last_shot = -1000;
    end else begin
      if (l && !r) m_x = (m_x - 2 < 20) ? 20 : m_x - 2;
      if (r && !l) m_x = (m_x + 2 > 600) ? 600 : m_x + 2;
      if (f && (AUTO || !m_pf) && (m_n - m_last_shot >= 16) && !b) begin
        m_shot = 1;
        m_last_shot = m_n;
      end
    end
    m_pf = f;
  endfunction

  function automatic int m_visible();
    if (m_over) return 0;
    if (m_hit_frame >= 0) return (((m_n - m_hit_frame) >> 2) & 1) ? 0 : 1;
    return 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
    model_step(keys, ba, hit_in);
    chk("x", int'(pif.player_x), m_x);
    chk("shoot", int'(pif.shoot_bullet), int'(m_shot));
    chk("visible", int'(pif.player_visible), m_visible());
    chk("lives", int'(pif.lives), m_lives);
    chk("game_over", int'(pif.game_over), int'(m_over));
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_x"}, int'(pif.player_x), 320);
    chk({tag, "_shoot"}, int'(pif.shoot_bullet), 0);
    chk({tag, "_lives"}, int'(pif.lives), 3);
    chk({tag, "_over"}, int'(pif.game_over), 0);
    chk({tag, "_vis"}, int'(pif.player_visible), 1);
  endtask

  // Called just after a tick; pulses Reset between clock edges.
  task automatic do_reset(string tag);
    #2 Reset = 1'b1;
    #1 check_reset_vals(tag);
    #1 Reset = 1'b0;
    model_reset();
  endtask

  task automatic idle(int n);
    keys = '0; ba = 0; hit_in = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [31:0] keys;
    logic        ba;
    int          exp_x;
    logic        exp_shoot;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [7:0] rand_slot();
    case ($urandom_range(0, 7))
      1: return 8'h04;
      2: return 8'h07;
      3, 4: return 8'h2C;
      5: return 8'($urandom_range(0, 255));
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    tbl[0] = '{32'h0000_0007, 1'b0, 322, 1'b0};
    tbl[1] = '{32'h0004_0700, 1'b0, 322, 1'b0};
    tbl[2] = '{32'h0400_0000, 1'b0, 320, 1'b0};
    tbl[3] = '{32'h0000_2C07, 1'b0, 322, 1'b1};
    tbl[4] = '{32'h0000_002C, 1'b0, 322, 1'b0};
    tbl[5] = '{32'h0000_0000, 1'b0, 322, 1'b0};
    tbl[6] = '{32'h2C00_0000, 1'b0, 322, 1'b0};
    tbl[7] = '{32'h0404_0404, 1'b0, 320, 1'b0};
    tbl[8] = '{32'h0000_2C07, 1'b1, 322, 1'b0};

    // Reset state while Reset is held.
    Reset = 1'b1;
    @(posedge frame_clk);
    @(posedge frame_clk);
    #1 check_reset_vals("reset");
    #2 Reset = 1'b0;
    model_reset();

    // Table-driven basics from reset.
    for (int i = 0; i < 9; i++) begin
      keys = tbl[i].keys; ba = tbl[i].ba; hit_in = 0;
      tick();
      chk($sformatf("tbl%0d_x", i), int'(pif.player_x), tbl[i].exp_x);
      chk($sformatf("tbl%0d_shoot", i), int'(pif.shoot_bullet), int'(tbl[i].exp_shoot));
    end

    // Right saturation.
    do_reset("rst_r");
    keys = 32'h0000_0007;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("x_le_max", int'(pif.player_x <= 10'd600), 1);
    end
    chk("x_sat_max", int'(pif.player_x), 600);

    // Left saturation, then both keys held.
    do_reset("rst_l");
    keys = 32'h0000_0004;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("x_ge_min", int'(pif.player_x >= 10'd20), 1);
    end
    chk("x_sat_min", int'(pif.player_x), 20);
    keys = 32'h0000_0407;
    tick();
    chk("x_both", int'(pif.player_x), 20);

    // Fire edge, cooldown and bullet_active gating.
    do_reset("rst_f");
    for (int i = 0; i < 36; i++) begin
      keys = (i == 0 || i == 2 || i == 16 || i == 32) ? 32'h0000_002C : 32'h0;
      ba = (i == 32);
      tick();
      chk($sformatf("fire%0d", i), int'(pif.shoot_bullet), int'(i == 0 || i == 16));
    end
    ba = 0;

    // Hit together with a fire edge and a move.
    do_reset("rst_h");
    keys = 32'h0000_2C07; hit_in = 1;
    tick();
    chk("hit_noshoot", int'(pif.shoot_bullet), 0);
    chk("hit_lives", int'(pif.lives), 2);
    chk("hit_x", int'(pif.player_x), 320);
    for (int j = 1; j <= 60; j++) begin
      hit_in = (j % 7 == 0);
      tick();
      chk("dying_x", int'(pif.player_x), 320);
      chk("dying_shoot", int'(pif.shoot_bullet), 0);
      if (j < 60) chk($sformatf("dying_vis%0d", j), int'(pif.player_visible), ((j >> 2) & 1) ? 0 : 1);
      else chk("respawn_vis", int'(pif.player_visible), 1);
    end
    hit_in = 0;
    tick();
    chk("respawn_move", int'(pif.player_x), 322);
`ifndef PLAYER_AUTOFIRE_EN
    chk("respawn_nofire", int'(pif.shoot_bullet), 0);
`endif

    // Two more deaths -> game over.
    for (int d = 0; d < 2; d++) begin
      hit_in = 1; tick(); hit_in = 0;
      for (int j = 0; j < 60; j++) tick();
      tick();
    end
    chk("over_flag", int'(pif.game_over), 1);
    chk("over_lives", int'(pif.lives), 0);
    chk("over_vis", int'(pif.player_visible), 0);
    for (int i = 0; i < 20; i++) begin
      keys = {rand_slot(), rand_slot(), rand_slot(), rand_slot()};
      tick();
    end
    do_reset("rst_over");

    // Reset mid-DYING and mid-cooldown.
    hit_in = 1; tick(); hit_in = 0; idle(10);
    do_reset("rst_dying");
    keys = 32'h0000_002C; tick(); idle(3);
    do_reset("rst_cd");
    keys = 32'h0000_002C; tick();
    chk("fire_after_rst", int'(pif.shoot_bullet), 1);

    // Random run against the model.
    for (int i = 0; i < 4000; i++) begin
      keys   = {rand_slot(), rand_slot(), rand_slot(), rand_slot()};
      ba     = ($urandom_range(0, 2) == 0);
      hit_in = ($urandom_range(0, 39) == 0);
      tick();
      if ($urandom_range(0, 299) == 0) do_reset("rst_rand");
    end

`ifdef PLAYER_AUTOFIRE_EN
    do_reset("rst_auto");
    keys = 32'h0000_002C; ba = 0; hit_in = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      chk($sformatf("auto%0d", i), int'(pif.shoot_bullet), int'(i % 16 == 0));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
